// File: rtl/redmule_tile_boot_ctrl_if.sv
// Control-plane bundle between the SoC/testbench and the RedMulE tile boot sequencer.
// The slave modport is the sequencer; the master modport is whoever drives start and monitors the core.
interface redmule_tile_boot_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              start_i;
  logic [31:0]       entry_addr_i;
  logic              mon_w_valid_i;
  logic [ADDR_W-1:0] mon_w_addr_i;
  logic [DATA_W-1:0] mon_w_data_i;
  logic              busy_i;
  logic [31:0]       boot_addr_o;
  logic              fetch_enable_o;
  logic              done_o;
  logic              timeout_o;
  logic [31:0]       exit_code_o;

  modport master (
    output start_i, entry_addr_i, mon_w_valid_i, mon_w_addr_i, mon_w_data_i, busy_i,
    input  boot_addr_o, fetch_enable_o, done_o, timeout_o, exit_code_o
  );

  modport slave (
    input  start_i, entry_addr_i, mon_w_valid_i, mon_w_addr_i, mon_w_data_i, busy_i,
    output boot_addr_o, fetch_enable_o, done_o, timeout_o, exit_code_o
  );
endinterface

// File: rtl/redmule_tile_boot_ctrl.sv
// Boot/run sequencer for a RedMulE tile: settle boot address, enable fetch, catch the EOC
// mailbox write, wait for the engine to drain, and report the exit code (watchdog-guarded).
module redmule_tile_boot_ctrl #(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter logic [ADDR_W-1:0] EOC_ADDR       = ADDR_W'(32'h2C03_0000),
  parameter int unsigned       SETTLE_CYCLES  = 16,
  parameter int unsigned       TIMEOUT_CYCLES = 1_000_000,
  parameter logic [31:0]       TO_CODE        = 32'hDEAD_0001
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  redmule_tile_boot_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam bit          WD_EN       = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WD_LAST     = WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_e      state_q, state_d;
  logic [31:0] boot_addr_q, boot_addr_d;
  logic        fetch_q, fetch_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic [31:0] exit_q, exit_d;
  logic [31:0] settle_q, settle_d;
  logic [31:0] wd_q, wd_d;

  logic        eoc_hit;
  logic        wd_expired;
  logic [31:0] wd_inc;

  assign eoc_hit = bus.mon_w_valid_i && (bus.mon_w_addr_i == EOC_ADDR) && (|bus.mon_w_data_i);
  // >= rather than == so a count that passed the limit while entering DRAIN still fires.
  assign wd_expired = WD_EN && (wd_q >= WD_LAST);
  assign wd_inc     = (wd_q == '1) ? wd_q : wd_q + 32'd1;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    boot_addr_d = boot_addr_q;
    fetch_d     = fetch_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    exit_d      = exit_q;
    settle_d    = settle_q;
    wd_d        = wd_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start_i) begin
          state_d     = ST_SETUP;
          boot_addr_d = bus.entry_addr_i;
          fetch_d     = 1'b0;
          done_d      = 1'b0;
          timeout_d   = 1'b0;
          exit_d      = 32'd0;
          settle_d    = 32'd0;
        end
      end
      ST_SETUP: begin
        fetch_d  = 1'b0;
        wd_d     = 32'd0;
        settle_d = settle_q + 32'd1;
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          fetch_d = 1'b1;
        end
      end
      ST_RUN: begin
        wd_d = wd_inc;
        if (eoc_hit) begin
          state_d = ST_DRAIN;
          exit_d  = 32'(bus.mon_w_data_i);
        end else if (wd_expired) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          fetch_d   = 1'b0;
          exit_d    = TO_CODE;
        end
      end
      ST_DRAIN: begin
        wd_d = wd_inc;
        if (!bus.busy_i) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          fetch_d = 1'b0;
        end else if (wd_expired) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          fetch_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      boot_addr_q <= 32'd0;
      fetch_q     <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      exit_q      <= 32'd0;
      settle_q    <= 32'd0;
      wd_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      boot_addr_q <= boot_addr_d;
      fetch_q     <= fetch_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      exit_q      <= exit_d;
      settle_q    <= settle_d;
      wd_q        <= wd_d;
    end
  end

  assign bus.boot_addr_o    = boot_addr_q;
  assign bus.fetch_enable_o = fetch_q;
  assign bus.done_o         = done_q;
  assign bus.timeout_o      = timeout_q;
  assign bus.exit_code_o    = exit_q;

endmodule
